lc3_writeback_stage: RTL and testbench



---
 rtl/lc3_writeback_stage_pkg.sv | 33 +++
 rtl/lc3_writeback_stage_regfile.sv | 36 +++
 rtl/lc3_writeback_stage.sv | 79 +++++++
 tb/tb_lc3_writeback_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_writeback_stage_pkg.sv
// LC3 writeback shared types: source select, register index, PSR codes.
// Also holds the nzp() helper shared with predictor and scoreboard code.
package lc3_wb_pkg_hdl;

    localparam int WB_DATA_W   = 16;
    localparam int WB_NUM_REGS = 8;

    typedef enum logic [1:0] {
        WB_ALU     = 2'd0,
        WB_MEM     = 2'd1,
        WB_PC      = 2'd2,
        WB_ILLEGAL = 2'd3
    } wb_src_t;

    typedef logic [2:0] reg_idx_t;
    typedef logic [2:0] psr_t;

    localparam psr_t PSR_N = 3'b100;
    localparam psr_t PSR_Z = 3'b010;
    localparam psr_t PSR_P = 3'b001;

    function automatic psr_t nzp(input logic [WB_DATA_W-1:0] value);
        psr_t r;
        r = PSR_P;
        if (value[WB_DATA_W-1]) begin
            r = PSR_N;
        end else if (value == '0) begin
            r = PSR_Z;
        end
        return r;
    endfunction

endpackage

// File: rtl/lc3_writeback_stage_regfile.sv
// LC3 register file: one synchronous write port, two async read ports,
// synchronous clear on reset.
module lc3_regfile
    import lc3_wb_pkg_hdl::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int NUM_REGS = WB_NUM_REGS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_we,
    input  logic [$clog2(NUM_REGS)-1:0] i_waddr,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [$clog2(NUM_REGS)-1:0] i_raddr1,
    input  logic [$clog2(NUM_REGS)-1:0] i_raddr2,
    output logic [DATA_W-1:0]           o_rdata1,
    output logic [DATA_W-1:0]           o_rdata2
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Reads come from the stored array only; no same-cycle bypass.
    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/lc3_writeback_stage.sv
// LC3 writeback stage: selects ALU/MEM/PC result, writes the register
// file, updates PSR condition codes and flags illegal source selects.
module lc3_writeback_stage
    import lc3_wb_pkg_hdl::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int NUM_REGS = WB_NUM_REGS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable_writeback,
    input  logic [1:0]                  W_Control,
    input  logic [DATA_W-1:0]           aluout,
    input  logic [DATA_W-1:0]           memout,
    input  logic [DATA_W-1:0]           pcout,
    input  logic [DATA_W-1:0]           npc,
    input  logic [$clog2(NUM_REGS)-1:0] sr1,
    input  logic [$clog2(NUM_REGS)-1:0] sr2,
    input  logic [$clog2(NUM_REGS)-1:0] dr,
    output logic [DATA_W-1:0]           VSR1,
    output logic [DATA_W-1:0]           VSR2,
    output psr_t                        psr,
    output logic                        wb_err
);

    logic [DATA_W-1:0] w_dr_in;
    logic              w_src_ok;
    logic              w_we;
    logic              w_npc_unused;
    psr_t              r_psr;
    logic              r_wb_err;

    // npc rides along for the monitor only; nothing here stores it.
    assign w_npc_unused = ^npc;

    always_comb begin
        w_dr_in  = '0;
        w_src_ok = 1'b1;
        unique case (wb_src_t'(W_Control))
            WB_ALU:     w_dr_in = aluout;
            WB_MEM:     w_dr_in = memout;
            WB_PC:      w_dr_in = pcout;
            WB_ILLEGAL: w_src_ok = 1'b0;
        endcase
    end

    assign w_we = enable_writeback & w_src_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_psr    <= '0;
            r_wb_err <= 1'b0;
        end else begin
            r_wb_err <= enable_writeback & ~w_src_ok;
            if (w_we) begin
                r_psr <= nzp(w_dr_in);
            end
        end
    end

    lc3_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .i_we     (w_we),
        .i_waddr  (dr),
        .i_wdata  (w_dr_in),
        .i_raddr1 (sr1),
        .i_raddr2 (sr2),
        .o_rdata1 (VSR1),
        .o_rdata2 (VSR2)
    );

    assign psr    = r_psr;
    assign wb_err = r_wb_err;

endmodule

// File: tb/tb_lc3_writeback_stage.sv
// Self-checking bench for lc3_writeback_stage: directed scenarios plus
// randomized traffic against a behavioural register-file model.
module tb_lc3_writeback_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_writeback = 1'b0;
    logic [1:0]  W_Control = 2'd0;
    logic [15:0] aluout = '0;
    logic [15:0] memout = '0;
    logic [15:0] pcout = '0;
    logic [15:0] npc = '0;
    logic [2:0]  sr1 = '0;
    logic [2:0]  sr2 = '0;
    logic [2:0]  dr = '0;
    logic [15:0] VSR1;
    logic [15:0] VSR2;
    logic [2:0]  psr;
    logic        wb_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] m_regs [8];
    logic [2:0]  m_psr;
    logic        m_err;

    lc3_writeback_stage dut (
        .clock            (clock),
        .reset            (reset),
        .enable_writeback (enable_writeback),
        .W_Control        (W_Control),
        .aluout           (aluout),
        .memout           (memout),
        .pcout            (pcout),
        .npc              (npc),
        .sr1              (sr1),
        .sr2              (sr2),
        .dr               (dr),
        .VSR1             (VSR1),
        .VSR2             (VSR2),
        .psr              (psr),
        .wb_err           (wb_err)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] ref_nzp(input logic [15:0] v);
        if (v == 16'd0) return 3'b010;
        if ($signed(v) < 0) return 3'b100;
        return 3'b001;
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        logic [15:0] v;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            m_psr = '0;
            m_err = 1'b0;
        end else if (enable_writeback) begin
            if (W_Control == 2'd3) begin
                m_err = 1'b1;
            end else begin
                v = (W_Control == 2'd0) ? aluout :
                    (W_Control == 2'd1) ? memout : pcout;
                m_regs[dr] = v;
                m_psr = ref_nzp(v);
                m_err = 1'b0;
            end
        end else begin
            m_err = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sr1 = 3'd3;
        sr2 = 3'd7;
        #1;
        total_cnt++;
        if (VSR1 !== 16'h0000) $display("FAIL reset_vsr1 got %h want 0000", VSR1);
        else pass_cnt++;
        total_cnt++;
        if (VSR2 !== 16'h0000) $display("FAIL reset_vsr2 got %h want 0000", VSR2);
        else pass_cnt++;
        total_cnt++;
        if (psr !== 3'b000) $display("FAIL reset_psr got %b want 000", psr);
        else pass_cnt++;
        total_cnt++;
        if (wb_err !== 1'b0) $display("FAIL reset_err got %b want 0", wb_err);
        else pass_cnt++;
    endtask

    task automatic test_alu_write();
        enable_writeback = 1'b1;
        W_Control = 2'd0;
        aluout = 16'h8001;
        dr = 3'd2;
        tick();
        enable_writeback = 1'b0;
        sr1 = 3'd2;
        #1;
        total_cnt++;
        if (VSR1 !== 16'h8001) $display("FAIL alu_vsr1 got %h want 8001", VSR1);
        else pass_cnt++;
        total_cnt++;
        if (psr !== 3'b100) $display("FAIL alu_psr got %b want 100", psr);
        else pass_cnt++;
    endtask

    task automatic test_mem_pc();
        enable_writeback = 1'b1;
        W_Control = 2'd1;
        memout = 16'h0000;
        aluout = 16'h1111;
        dr = 3'd4;
        tick();
        total_cnt++;
        if (psr !== 3'b010) $display("FAIL mem_psr got %b want 010", psr);
        else pass_cnt++;
        W_Control = 2'd2;
        pcout = 16'h3005;
        memout = 16'hFFFF;
        dr = 3'd5;
        tick();
        total_cnt++;
        if (psr !== 3'b001) $display("FAIL pc_psr got %b want 001", psr);
        else pass_cnt++;
        enable_writeback = 1'b0;
        sr1 = 3'd4;
        sr2 = 3'd5;
        #1;
        total_cnt++;
        if (VSR1 !== 16'h0000) $display("FAIL mem_vsr1 got %h want 0000", VSR1);
        else pass_cnt++;
        total_cnt++;
        if (VSR2 !== 16'h3005) $display("FAIL pc_vsr2 got %h want 3005", VSR2);
        else pass_cnt++;
    endtask

    task automatic test_no_write_through();
        enable_writeback = 1'b1;
        W_Control = 2'd0;
        aluout = 16'h00AA;
        dr = 3'd1;
        tick();
        aluout = 16'h0055;
        sr1 = 3'd1;
        sr2 = 3'd1;
        #1;
        total_cnt++;
        if (VSR1 !== 16'h00AA) $display("FAIL nwt_same_cycle got %h want 00aa", VSR1);
        else pass_cnt++;
        tick();
        enable_writeback = 1'b0;
        total_cnt++;
        if (VSR1 !== 16'h0055) $display("FAIL nwt_next_cycle got %h want 0055", VSR1);
        else pass_cnt++;
        total_cnt++;
        if (VSR2 !== 16'h0055) $display("FAIL nwt_port2_same got %h want 0055", VSR2);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        enable_writeback = 1'b1;
        W_Control = 2'd0;
        dr = 3'd3;
        sr1 = 3'd3;
        aluout = 16'hF000;
        tick();
        total_cnt++;
        if (VSR1 !== 16'hF000 || psr !== 3'b100)
            $display("FAIL b2b_first got %h/%b want f000/100", VSR1, psr);
        else pass_cnt++;
        W_Control = 2'd2;
        pcout = 16'h0007;
        tick();
        enable_writeback = 1'b0;
        total_cnt++;
        if (VSR1 !== 16'h0007 || psr !== 3'b001)
            $display("FAIL b2b_second got %h/%b want 0007/001", VSR1, psr);
        else pass_cnt++;
    endtask

    task automatic test_illegal_disabled();
        logic [15:0] old_r6;
        logic [2:0]  old_psr;
        old_r6 = m_regs[6];
        old_psr = m_psr;
        enable_writeback = 1'b1;
        W_Control = 2'd3;
        dr = 3'd6;
        aluout = 16'h1234;
        sr1 = 3'd6;
        tick();
        total_cnt++;
        if (wb_err !== 1'b1) $display("FAIL ill_err got %b want 1", wb_err);
        else pass_cnt++;
        total_cnt++;
        if (VSR1 !== old_r6 || psr !== old_psr)
            $display("FAIL ill_state got %h/%b want %h/%b", VSR1, psr, old_r6, old_psr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wb_err !== 1'b1) $display("FAIL ill_repeat_err got %b want 1", wb_err);
        else pass_cnt++;
        enable_writeback = 1'b0;
        W_Control = 2'd0;
        tick();
        total_cnt++;
        if (wb_err !== 1'b0) $display("FAIL dis_err got %b want 0", wb_err);
        else pass_cnt++;
        total_cnt++;
        if (VSR1 !== old_r6 || psr !== old_psr)
            $display("FAIL dis_state got %h/%b want %h/%b", VSR1, psr, old_r6, old_psr);
        else pass_cnt++;
    endtask

    task automatic test_reset_collision();
        enable_writeback = 1'b1;
        W_Control = 2'd0;
        aluout = 16'h7FFF;
        dr = 3'd0;
        sr1 = 3'd0;
        sr2 = 3'd6;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        enable_writeback = 1'b0;
        total_cnt++;
        if (VSR1 !== 16'h0000) $display("FAIL rstcol_r0 got %h want 0000", VSR1);
        else pass_cnt++;
        total_cnt++;
        if (psr !== 3'b000) $display("FAIL rstcol_psr got %b want 000", psr);
        else pass_cnt++;
        total_cnt++;
        if (VSR2 !== 16'h0000) $display("FAIL rstcol_r6 got %h want 0000", VSR2);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] pre1;
        for (int n = 0; n < 300; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            enable_writeback = ($urandom_range(0, 3) != 0);
            W_Control = 2'($urandom_range(0, 3));
            aluout = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            memout = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            pcout = 16'($urandom);
            npc = 16'($urandom);
            dr = 3'($urandom);
            sr1 = ($urandom_range(0, 1) == 0) ? dr : 3'($urandom);
            sr2 = 3'($urandom);
            #1;
            pre1 = m_regs[sr1];
            total_cnt++;
            if (VSR1 !== pre1) $display("FAIL rnd_pre_vsr1 n=%0d got %h want %h", n, VSR1, pre1);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (VSR1 !== m_regs[sr1] || VSR2 !== m_regs[sr2] ||
                psr !== m_psr || wb_err !== m_err)
                $display("FAIL rnd_post n=%0d got %h %h %b %b want %h %h %b %b",
                         n, VSR1, VSR2, psr, wb_err,
                         m_regs[sr1], m_regs[sr2], m_psr, m_err);
            else pass_cnt++;
        end
        reset = 1'b0;
        enable_writeback = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_psr = '0;
        m_err = 1'b0;
        #2;
        test_reset();
        test_alu_write();
        test_mem_pc();
        test_no_write_through();
        test_back_to_back();
        test_illegal_disabled();
        test_reset_collision();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
